// File: rtl/ex_hilo_unit.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO and a multi-cycle
// restoring DIV/DIVU that stalls the pipeline until its result is ready.
module ex_hilo_unit #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op_i,
   input  logic [DIV_W-1:0] reg1_i,
   input  logic [DIV_W-1:0] reg2_i,
   input  logic [DIV_W-1:0] hi_i,
   input  logic [DIV_W-1:0] lo_i,
   input  logic             flush_i,
   input  logic             stall_i,
   output logic             whilo_o,
   output logic [DIV_W-1:0] hi_o,
   output logic [DIV_W-1:0] lo_o,
   output logic             stallreq_o
);

   localparam int CW = $clog2(DIV_W);
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {IDLE, DIV_ON, DIV_END} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [DIV_W-1:0] rem_q, quo_q, dsr_q;
   logic             sign_q, sign_r;

   logic is_div, signed_div, dsr_zero, last_step;
   assign is_div     = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign signed_div = (op_i == OP_DIV);
   assign dsr_zero   = (reg2_i == '0);
   assign last_step  = (cnt == CW'(DIV_W-1));

   // Operands widened to the full product width so the low half of the
   // wide multiply is the exact 2*DIV_W-bit product.
   logic [2*DIV_W-1:0] prod_s, prod_u;
   assign prod_s = {{DIV_W{reg1_i[DIV_W-1]}}, reg1_i} * {{DIV_W{reg2_i[DIV_W-1]}}, reg2_i};
   assign prod_u = {{DIV_W{1'b0}}, reg1_i} * {{DIV_W{1'b0}}, reg2_i};

   // One restoring step: shift the next dividend bit into the remainder and
   // keep the subtraction only if it does not go negative.
   logic [DIV_W:0]   rem_sh;
   logic [DIV_W-1:0] sub, r_next, q_next;
   logic             ge;
   assign rem_sh = {rem_q, quo_q[DIV_W-1]};
   assign ge     = rem_sh >= {1'b0, dsr_q};
   assign sub    = rem_sh[DIV_W-1:0] - dsr_q;
   assign r_next = ge ? sub : rem_sh[DIV_W-1:0];
   assign q_next = {quo_q[DIV_W-2:0], ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush_i) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (is_div) state_nx = dsr_zero ? DIV_END : DIV_ON;
            DIV_ON:  if (!is_div) state_nx = IDLE;
                     else if (last_step) state_nx = DIV_END;
            DIV_END: if (!stall_i) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (is_div && !flush_i) begin
               cnt <= '0;
               if (dsr_zero) begin
                  quo_q <= '1;
                  rem_q <= reg1_i;
               end else begin
                  quo_q  <= (signed_div && reg1_i[DIV_W-1]) ? -reg1_i : reg1_i;
                  dsr_q  <= (signed_div && reg2_i[DIV_W-1]) ? -reg2_i : reg2_i;
                  rem_q  <= '0;
                  sign_q <= signed_div && (reg1_i[DIV_W-1] ^ reg2_i[DIV_W-1]);
                  sign_r <= signed_div && reg1_i[DIV_W-1];
               end
            end
            DIV_ON: begin
               cnt <= cnt + CW'(1);
               if (last_step) begin
                  quo_q <= sign_q ? -q_next : q_next;
                  rem_q <= sign_r ? -r_next : r_next;
               end else begin
                  quo_q <= q_next;
                  rem_q <= r_next;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      if (!rst && !flush_i) begin
         case (state)
            DIV_END: begin
               whilo_o = 1'b1;
               hi_o    = rem_q;
               lo_o    = quo_q;
            end
            DIV_ON: stallreq_o = is_div;
            default: begin
               case (op_i)
                  OP_MULT:  begin whilo_o = 1'b1; {hi_o, lo_o} = prod_s; end
                  OP_MULTU: begin whilo_o = 1'b1; {hi_o, lo_o} = prod_u; end
                  OP_MTHI:  begin whilo_o = 1'b1; hi_o = reg1_i; lo_o = lo_i; end
                  OP_MTLO:  begin whilo_o = 1'b1; hi_o = hi_i; lo_o = reg1_i; end
                  OP_DIV, OP_DIVU: stallreq_o = 1'b1;
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// Directed bench for ex_hilo_unit: multiply/move ops, divider latency,
// signed fix-up, divide by zero, stall hold, flush and reset aborts.
module tb_ex_hilo_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  op_i;
   logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
   logic        flush_i, stall_i;
   logic        whilo_o, stallreq_o;
   logic [31:0] hi_o, lo_o;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [2:0] NOP = 3'b000, MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                          DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

   ex_hilo_unit #(.DIV_W(32)) dut (
      .clk(clk), .rst(rst), .op_i(op_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i), .stall_i(stall_i),
      .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; outputs are sampled 1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int ncyc, output logic w, output logic [31:0] hi, output logic [31:0] lo);
      op_i = op; reg1_i = a; reg2_i = b;
      #1;
      ncyc = 0;
      while (stallreq_o && ncyc < 100) begin
         ncyc++;
         tick();
      end
      w = whilo_o; hi = hi_o; lo = lo_o;
   endtask

   task automatic test_reset();
      op_i = DIV; reg1_i = 32'd9; reg2_i = 32'd3; hi_i = 0; lo_i = 0;
      flush_i = 0; stall_i = 0; rst = 1;
      #1;
      n_cmp++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
         n_bad++; $display("FAIL reset_outputs: got w=%b s=%b hi=%h lo=%h want all 0", whilo_o, stallreq_o, hi_o, lo_o);
      end
      tick(); op_i = NOP; tick(); rst = 0; #1;
      n_cmp++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
         n_bad++; $display("FAIL post_reset_nop: got w=%b s=%b hi=%h lo=%h want all 0", whilo_o, stallreq_o, hi_o, lo_o);
      end
   endtask

   task automatic test_mult();
      op_i = MULT; reg1_i = 32'hFFFF_FFFD; reg2_i = 32'd5; #1;
      n_cmp++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== {1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
         n_bad++; $display("FAIL mult_neg3x5: got w=%b s=%b hi=%h lo=%h want 1 0 ffffffff fffffff1", whilo_o, stallreq_o, hi_o, lo_o);
      end
      op_i = MULTU; reg1_i = 32'hFFFF_FFFF; reg2_i = 32'd2; #1;
      n_cmp++;
      if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'h0000_0001, 32'hFFFF_FFFE}) begin
         n_bad++; $display("FAIL multu_max_x2: got w=%b hi=%h lo=%h want 1 00000001 fffffffe", whilo_o, hi_o, lo_o);
      end
      op_i = MULT; #1;
      n_cmp++;
      if ({hi_o, lo_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
         n_bad++; $display("FAIL mult_neg1x2: got hi=%h lo=%h want ffffffff fffffffe", hi_o, lo_o);
      end
      flush_i = 1; #1;
      n_cmp++;
      if ({whilo_o, hi_o, lo_o} !== 65'd0) begin
         n_bad++; $display("FAIL mult_flushed: got w=%b hi=%h lo=%h want all 0", whilo_o, hi_o, lo_o);
      end
      flush_i = 0; op_i = 3'b111; #1;
      n_cmp++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
         n_bad++; $display("FAIL nop_111: got w=%b s=%b hi=%h lo=%h want all 0", whilo_o, stallreq_o, hi_o, lo_o);
      end
   endtask

   task automatic test_mthilo();
      op_i = MTHI; reg1_i = 32'h1234_5678; lo_i = 32'd9; hi_i = 32'h55; #1;
      n_cmp++;
      if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'h1234_5678, 32'h0000_0009}) begin
         n_bad++; $display("FAIL mthi: got w=%b hi=%h lo=%h want 1 12345678 00000009", whilo_o, hi_o, lo_o);
      end
      op_i = MTLO; reg1_i = 32'hCAFE_BABE; #1;
      n_cmp++;
      if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'h0000_0055, 32'hCAFE_BABE}) begin
         n_bad++; $display("FAIL mtlo: got w=%b hi=%h lo=%h want 1 00000055 cafebabe", whilo_o, hi_o, lo_o);
      end
      op_i = NOP; tick();
   endtask

   task automatic test_divu();
      int n; logic w; logic [31:0] hi, lo;
      run_div(DIVU, 32'd100, 32'd7, n, w, hi, lo);
      n_cmp++;
      if (n !== 33) begin
         n_bad++; $display("FAIL divu_stall_cycles: got %0d want 33", n);
      end
      n_cmp++;
      if ({w, hi, lo} !== {1'b1, 32'd2, 32'd14}) begin
         n_bad++; $display("FAIL divu_100_7: got w=%b hi=%h lo=%h want 1 00000002 0000000e", w, hi, lo);
      end
      op_i = NOP; tick();
      n_cmp++;
      if ({whilo_o, stallreq_o} !== 2'b00) begin
         n_bad++; $display("FAIL divu_back_to_idle: got w=%b s=%b want 0 0", whilo_o, stallreq_o);
      end
   endtask

   task automatic test_div_signed();
      int n; logic w; logic [31:0] hi, lo;
      run_div(DIV, 32'hFFFF_FFF9, 32'd2, n, w, hi, lo);
      n_cmp++;
      if ({n, w, hi, lo} !== {32'd33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
         n_bad++; $display("FAIL div_neg7_2: got n=%0d w=%b hi=%h lo=%h want 33 1 ffffffff fffffffd", n, w, hi, lo);
      end
      op_i = NOP; tick();
      run_div(DIV, 32'd7, 32'hFFFF_FFFE, n, w, hi, lo);
      n_cmp++;
      if ({w, hi, lo} !== {1'b1, 32'd1, 32'hFFFF_FFFD}) begin
         n_bad++; $display("FAIL div_7_neg2: got w=%b hi=%h lo=%h want 1 00000001 fffffffd", w, hi, lo);
      end
      op_i = NOP; tick();
      run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, w, hi, lo);
      n_cmp++;
      if ({w, hi, lo} !== {1'b1, 32'd0, 32'h8000_0000}) begin
         n_bad++; $display("FAIL div_min_neg1: got w=%b hi=%h lo=%h want 1 00000000 80000000", w, hi, lo);
      end
      op_i = NOP; tick();
   endtask

   task automatic test_div_zero();
      int n; logic w; logic [31:0] hi, lo;
      run_div(DIVU, 32'd5, 32'd0, n, w, hi, lo);
      n_cmp++;
      if ({n, w, hi, lo} !== {32'd1, 1'b1, 32'd5, 32'hFFFF_FFFF}) begin
         n_bad++; $display("FAIL divu_by_zero: got n=%0d w=%b hi=%h lo=%h want 1 1 00000005 ffffffff", n, w, hi, lo);
      end
      op_i = NOP; tick();
      stall_i = 1;
      run_div(DIVU, 32'd5, 32'd0, n, w, hi, lo);
      op_i = NOP;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({whilo_o, stallreq_o, hi_o, lo_o} !== {1'b1, 1'b0, 32'd5, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL stall_hold_%0d: got w=%b s=%b hi=%h lo=%h want 1 0 00000005 ffffffff", i, whilo_o, stallreq_o, hi_o, lo_o);
         end
      end
      stall_i = 0; tick();
      n_cmp++;
      if (whilo_o !== 1'b0) begin
         n_bad++; $display("FAIL stall_release: got w=%b want 0", whilo_o);
      end
   endtask

   task automatic test_abort();
      int n; logic w; logic [31:0] hi, lo;
      op_i = DIV; reg1_i = 32'd1000; reg2_i = 32'd3;
      for (int i = 0; i < 10; i++) tick();
      flush_i = 1; #1;
      n_cmp++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
         n_bad++; $display("FAIL flush_outputs: got w=%b s=%b hi=%h lo=%h want all 0", whilo_o, stallreq_o, hi_o, lo_o);
      end
      tick(); flush_i = 0; op_i = NOP; #1;
      n_cmp++;
      if ({whilo_o, stallreq_o} !== 2'b00) begin
         n_bad++; $display("FAIL flush_idle: got w=%b s=%b want 0 0", whilo_o, stallreq_o);
      end
      op_i = DIVU; tick(); tick(); tick();
      op_i = NOP; #1;
      n_cmp++;
      if (stallreq_o !== 1'b0) begin
         n_bad++; $display("FAIL op_change_abort: got s=%b want 0", stallreq_o);
      end
      tick();
      op_i = DIV; reg1_i = 32'd50; reg2_i = 32'd5;
      for (int i = 0; i < 5; i++) tick();
      rst = 1; #1;
      n_cmp++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
         n_bad++; $display("FAIL rst_mid_div: got w=%b s=%b hi=%h lo=%h want all 0", whilo_o, stallreq_o, hi_o, lo_o);
      end
      op_i = NOP; tick(); rst = 0; tick();
      n_cmp++;
      if ({whilo_o, stallreq_o} !== 2'b00) begin
         n_bad++; $display("FAIL rst_no_partial: got w=%b s=%b want 0 0", whilo_o, stallreq_o);
      end
      run_div(DIVU, 32'd100, 32'd7, n, w, hi, lo);
      n_cmp++;
      if ({n, w, hi, lo} !== {32'd33, 1'b1, 32'd2, 32'd14}) begin
         n_bad++; $display("FAIL div_after_rst: got n=%0d w=%b hi=%h lo=%h want 33 1 00000002 0000000e", n, w, hi, lo);
      end
      op_i = NOP; tick();
   endtask

   initial begin
      test_reset();
      tick();
      test_mult();
      test_mthilo();
      test_divu();
      test_div_signed();
      test_div_zero();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
